// File: rtl/vector_processor_pkg.sv
// Shared constants, opcode encoding and vector type for the vector processor.
// Optional feature macro: MEM_INIT_EN (memory reset contents, used in the top).
package vector_processor_pkg;

  localparam int LANES     = 16;
  localparam int LANE_W    = 32;
  localparam int MEM_DEPTH = 512;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int VEC_W     = LANES * LANE_W;
  localparam int NUM_REGS  = 4;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_ADD   = 2'd2,
    OP_MUL   = 2'd3
  } opcode_e;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

endpackage

// File: rtl/vector_alu.sv
// Combinational lane-wise signed add/multiply; lo feeds A3, hi feeds A4.
module vector_alu
  import vector_processor_pkg::*;
(
  input  vec_t i_a1,
  input  vec_t i_a2,
  input  logic i_mul,
  output vec_t o_lo,
  output vec_t o_hi
);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W:0]          w_sum;
      logic signed [2*LANE_W-1:0] w_a_ext;
      logic signed [2*LANE_W-1:0] w_b_ext;
      logic signed [2*LANE_W-1:0] w_prod;

      // One extra bit keeps the true signed sum; its top bit becomes the A4 lane.
      assign w_sum   = {i_a1[gi][LANE_W-1], i_a1[gi]} + {i_a2[gi][LANE_W-1], i_a2[gi]};
      assign w_a_ext = (2*LANE_W)'($signed(i_a1[gi]));
      assign w_b_ext = (2*LANE_W)'($signed(i_a2[gi]));
      assign w_prod  = w_a_ext * w_b_ext;

      assign o_lo[gi] = i_mul ? w_prod[LANE_W-1:0] : w_sum[LANE_W-1:0];
      assign o_hi[gi] = i_mul ? w_prod[2*LANE_W-1:LANE_W] : {LANE_W{w_sum[LANE_W]}};
    end
  endgenerate

endmodule

// File: rtl/vector_processor.sv
// Single-cycle vector processor: four 512-bit registers, 512x32 memory, lane ALU.
// Define MEM_INIT_EN to reset memory to mem[k] = k instead of zero.
module vector_processor
  import vector_processor_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       opcode,
  input  logic [9:0]       entry1,
  input  logic [1:0]       entry2,
  input  logic [1:0]       dbg_sel,
  output logic [VEC_W-1:0] dbg_data
);

  vec_t              r_regs [NUM_REGS];
  logic [LANE_W-1:0] r_mem  [MEM_DEPTH];

  opcode_e           w_op;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr [LANES];
  vec_t              w_load_vec;
  vec_t              w_alu_lo;
  vec_t              w_alu_hi;
  logic              w_is_mul;
  logic              w_unused_entry1_msb;

  assign w_op                = opcode_e'(opcode);
  assign w_base              = entry1[ADDR_W-1:0];
  assign w_unused_entry1_msb = entry1[9];
  assign w_is_mul            = (w_op == OP_MUL);

  // Lane addresses wrap naturally at the 9-bit address width.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_addr
      assign w_addr[gi]     = w_base + ADDR_W'(gi);
      assign w_load_vec[gi] = r_mem[w_addr[gi]];
    end
  endgenerate

  vector_alu u_alu (
    .i_a1  (r_regs[0]),
    .i_a2  (r_regs[1]),
    .i_mul (w_is_mul),
    .o_lo  (w_alu_lo),
    .o_hi  (w_alu_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= '0;
      end
      for (int k = 0; k < MEM_DEPTH; k++) begin
`ifdef MEM_INIT_EN
        r_mem[k] <= LANE_W'(k);
`else
        r_mem[k] <= '0;
`endif
      end
    end else begin
      case (w_op)
        OP_LOAD: r_regs[entry2] <= w_load_vec;
        OP_STORE: begin
          for (int i = 0; i < LANES; i++) begin
            r_mem[w_addr[i]] <= r_regs[entry2][i];
          end
        end
        OP_ADD, OP_MUL: begin
          r_regs[2] <= w_alu_lo;
          r_regs[3] <= w_alu_hi;
        end
        default: ;
      endcase
    end
  end

  assign dbg_data = r_regs[dbg_sel];

endmodule

// File: tb/tb_vector_processor.sv
// Directed self-checking bench for vector_processor; works with or without MEM_INIT_EN.
module tb_vector_processor;

  logic         clk;
  logic         rst_n;
  logic [1:0]   opcode;
  logic [9:0]   entry1;
  logic [1:0]   entry2;
  logic [1:0]   dbg_sel;
  logic [511:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  vector_processor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .entry1   (entry1),
    .entry2   (entry2),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [511:0] ramp(input int start);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'((start + i) % 512);
    return r;
  endfunction

  // Backdoor memory preload of operand vectors.
  task automatic preload(input int base, input logic [511:0] v);
    for (int i = 0; i < 16; i++) dut.r_mem[(base + i) % 512] = v[i*32 +: 32];
  endtask

  task automatic exec(input logic [1:0] op, input logic [9:0] e1, input logic [1:0] e2);
    @(negedge clk);
    opcode = op;
    entry1 = e1;
    entry2 = e2;
    @(posedge clk);
    #1;
    $display("txn op=%0d entry1=%0d entry2=%0d", op, e1, e2);
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    opcode  = 2'd2;
    entry1  = '0;
    entry2  = '0;
    dbg_sel = '0;
    #1 rst_n = 1'b0;
    for (int s = 0; s < 4; s++) begin
      dbg_sel = 2'(s);
      #1;
      checks++;
      if (dbg_data !== '0) begin
        failures++;
        $display("FAIL reset_sel%0d got=%h exp=0", s, dbg_data);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
`ifndef MEM_INIT_EN
    for (int k = 0; k < 512; k++) dut.r_mem[k] = 32'(k);
`endif
  endtask

  task automatic test_load();
    exec(2'd0, 10'd5, 2'd2);
    dbg_sel = 2'd2;
    #1;
    checks++;
    if (dbg_data !== ramp(5)) begin
      failures++;
      $display("FAIL load_base5 got=%h exp=%h", dbg_data, ramp(5));
    end
  endtask

  task automatic test_load_wrap();
    exec(2'd0, 10'd500, 2'd1);
    dbg_sel = 2'd1;
    #1;
    checks++;
    if (dbg_data !== ramp(500)) begin
      failures++;
      $display("FAIL load_wrap500 got=%h exp=%h", dbg_data, ramp(500));
    end
    checks++;
    if (dbg_data[15*32 +: 32] !== 32'd3) begin
      failures++;
      $display("FAIL load_wrap_lane15 got=%0d exp=3", dbg_data[15*32 +: 32]);
    end
  endtask

  task automatic test_store();
    logic [511:0] exp;
    exec(2'd0, 10'd384, 2'd3);
    exec(2'd1, 10'd400, 2'd3);
    exec(2'd0, 10'd400, 2'd0);
    dbg_sel = 2'd0;
    #1;
    checks++;
    if (dbg_data !== ramp(384)) begin
      failures++;
      $display("FAIL store400_readback got=%h exp=%h", dbg_data, ramp(384));
    end
    exec(2'd1, 10'd511, 2'd0);
    dbg_sel = 2'd0;
    #1;
    checks++;
    if (dbg_data !== ramp(384)) begin
      failures++;
      $display("FAIL store_keeps_reg got=%h exp=%h", dbg_data, ramp(384));
    end
    exec(2'd0, 10'd511, 2'd1);
    dbg_sel = 2'd1;
    #1;
    checks++;
    if (dbg_data !== ramp(384)) begin
      failures++;
      $display("FAIL store511_wrap_readback got=%h exp=%h", dbg_data, ramp(384));
    end
    // entry1 bit 9 ignored: base 517 acts as base 5, partly overwritten by the wrapped store.
    for (int i = 0; i < 16; i++) exp[i*32 +: 32] = (i < 10) ? 32'(390 + i) : 32'(5 + i);
    exec(2'd0, 10'd517, 2'd2);
    dbg_sel = 2'd2;
    #1;
    checks++;
    if (dbg_data !== exp) begin
      failures++;
      $display("FAIL load_bit9_ignored got=%h exp=%h", dbg_data, exp);
    end
  endtask

  task automatic test_mul();
    logic [31:0]  a [16];
    logic [31:0]  b [16];
    logic [511:0] va, vb, elo, ehi;
    longint       p;
    a[0] = 32'hFFFF_FFFE; b[0] = 32'hFFFF_FFFD;
    a[1] = 32'h7FFF_FFFF; b[1] = 32'd2;
    a[2] = 32'hFFFF_FFFF; b[2] = 32'd1;
    a[3] = 32'h8000_0000; b[3] = 32'h8000_0000;
    a[4] = 32'h0001_0000; b[4] = 32'h0001_0000;
    for (int i = 5; i < 16; i++) begin
      a[i] = 32'(i * 7 - 60);
      b[i] = 32'(1000 - i * 123);
    end
    for (int i = 0; i < 16; i++) begin
      va[i*32 +: 32]  = a[i];
      vb[i*32 +: 32]  = b[i];
      p = longint'($signed(a[i])) * longint'($signed(b[i]));
      elo[i*32 +: 32] = p[31:0];
      ehi[i*32 +: 32] = p[63:32];
    end
    preload(100, va);
    preload(200, vb);
    exec(2'd0, 10'd100, 2'd0);
    exec(2'd0, 10'd200, 2'd1);
    exec(2'd3, 10'd0, 2'd0);
    for (int pass = 0; pass < 2; pass++) begin
      dbg_sel = 2'd2;
      #1;
      checks++;
      if (dbg_data !== elo) begin
        failures++;
        $display("FAIL mul_lo_pass%0d got=%h exp=%h", pass, dbg_data, elo);
      end
      checks++;
      if (dbg_data[31:0] !== 32'd6 || dbg_data[63:32] !== 32'hFFFF_FFFE) begin
        failures++;
        $display("FAIL mul_lo_lanes01 got=%h,%h exp=6,fffffffe", dbg_data[31:0], dbg_data[63:32]);
      end
      dbg_sel = 2'd3;
      #1;
      checks++;
      if (dbg_data !== ehi) begin
        failures++;
        $display("FAIL mul_hi_pass%0d got=%h exp=%h", pass, dbg_data, ehi);
      end
      checks++;
      if (dbg_data[31:0] !== 32'd0 || dbg_data[3*32 +: 32] !== 32'h4000_0000) begin
        failures++;
        $display("FAIL mul_hi_lanes03 got=%h,%h exp=0,40000000", dbg_data[31:0], dbg_data[3*32 +: 32]);
      end
      dbg_sel = 2'd0;
      #1;
      checks++;
      if (dbg_data !== va) begin
        failures++;
        $display("FAIL mul_a1_unchanged got=%h exp=%h", dbg_data, va);
      end
      dbg_sel = 2'd1;
      #1;
      checks++;
      if (dbg_data !== vb) begin
        failures++;
        $display("FAIL mul_a2_unchanged got=%h exp=%h", dbg_data, vb);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_add();
    logic [31:0]  a [16];
    logic [31:0]  b [16];
    logic [511:0] va, vb, elo, ehi;
    longint       s;
    a[0] = 32'hFFFF_FFF9; b[0] = 32'd7;
    a[1] = 32'h8000_0000; b[1] = 32'h8000_0000;
    a[2] = 32'h7FFF_FFFF; b[2] = 32'd1;
    a[3] = 32'hFFFF_FFFF; b[3] = 32'hFFFF_FFFF;
    for (int i = 4; i < 16; i++) begin
      a[i] = 32'(i * 1001 - 9000);
      b[i] = 32'(i * 77 + 5);
    end
    for (int i = 0; i < 16; i++) begin
      va[i*32 +: 32]  = a[i];
      vb[i*32 +: 32]  = b[i];
      s = longint'($signed(a[i])) + longint'($signed(b[i]));
      elo[i*32 +: 32] = s[31:0];
      ehi[i*32 +: 32] = s[63:32];
    end
    preload(120, va);
    preload(220, vb);
    exec(2'd0, 10'd120, 2'd0);
    exec(2'd0, 10'd220, 2'd1);
    exec(2'd2, 10'd0, 2'd0);
    dbg_sel = 2'd2;
    #1;
    checks++;
    if (dbg_data !== elo) begin
      failures++;
      $display("FAIL add_lo got=%h exp=%h", dbg_data, elo);
    end
    checks++;
    if (dbg_data[31:0] !== 32'd0 || dbg_data[63:32] !== 32'd0 || dbg_data[95:64] !== 32'h8000_0000) begin
      failures++;
      $display("FAIL add_lo_lanes012 got=%h,%h,%h exp=0,0,80000000", dbg_data[31:0], dbg_data[63:32], dbg_data[95:64]);
    end
    dbg_sel = 2'd3;
    #1;
    checks++;
    if (dbg_data !== ehi) begin
      failures++;
      $display("FAIL add_hi got=%h exp=%h", dbg_data, ehi);
    end
    checks++;
    if (dbg_data[31:0] !== 32'd0 || dbg_data[63:32] !== 32'hFFFF_FFFF || dbg_data[95:64] !== 32'd0) begin
      failures++;
      $display("FAIL add_hi_lanes012 got=%h,%h,%h exp=0,ffffffff,0", dbg_data[31:0], dbg_data[63:32], dbg_data[95:64]);
    end
  endtask

  task automatic test_async_reset();
    logic [511:0] exp;
    exec(2'd3, 10'd0, 2'd0);
    #4 rst_n = 1'b0;
    for (int s = 0; s < 4; s++) begin
      dbg_sel = 2'(s);
      #1;
      checks++;
      if (dbg_data !== '0) begin
        failures++;
        $display("FAIL async_reset_sel%0d got=%h exp=0", s, dbg_data);
      end
    end
    @(posedge clk);
    #1;
    dbg_sel = 2'd2;
    #1;
    checks++;
    if (dbg_data !== '0) begin
      failures++;
      $display("FAIL reset_held_mul got=%h exp=0", dbg_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MEM_INIT_EN
    exp = ramp(5);
`else
    exp = '0;
`endif
    exec(2'd0, 10'd5, 2'd2);
    dbg_sel = 2'd2;
    #1;
    checks++;
    if (dbg_data !== exp) begin
      failures++;
      $display("FAIL mem_after_reset got=%h exp=%h", dbg_data, exp);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_wrap();
    test_store();
    test_mul();
    test_add();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
